// File: rtl/line_burst_adapter.sv
// Splits 128-bit line read/write requests into BEAT_WIDTH beats on a valid/ready memory
// command bus, reassembles in-order read beats and pulses physical_resp once per line.
module line_burst_adapter #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  physical_read,
  input  logic                  physical_write,
  input  logic [15:0]           physical_address,
  input  logic [LINE_WIDTH-1:0] physical_wdata,
  output logic                  physical_resp,
  output logic [LINE_WIDTH-1:0] physical_rdata,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [15:0]           mem_addr,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned Beats     = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW      = $clog2(Beats + 1);
  localparam int unsigned LineBytes = LINE_WIDTH / 8;
  localparam int unsigned BeatBytes = BEAT_WIDTH / 8;

  localparam logic [15:0]     LineMask = ~16'(LineBytes - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(Beats - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(Beats);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StResp,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_write_q, op_write_d;
  logic [CntW-1:0]       cmd_cnt_q, cmd_cnt_d;
  logic [CntW-1:0]       data_cnt_q, data_cnt_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic                  cmd_fire;
  logic                  beat_capture;
  logic [15:0]           beat_offset;
  logic [BEAT_WIDTH-1:0] beat_wdata;

  assign cmd_fire     = (state_q == StIssue) && mem_cmd_ready;
  // Read beats only count while a read line is in flight and the line is not yet full.
  assign beat_capture = ((state_q == StIssue) || (state_q == StDrain)) && !op_write_q &&
                        mem_rvalid && (data_cnt_q < FullCnt);
  assign beat_offset  = 16'(cmd_cnt_q) * 16'(BeatBytes);

  always_comb begin
    beat_wdata = '0;
    for (int unsigned b = 0; b < Beats; b++) begin
      if (cmd_cnt_q == CntW'(b)) begin
        beat_wdata = wdata_q[b*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

  // Command outputs are driven only in StIssue so the bus idles at zero.
  always_comb begin
    mem_cmd_valid = 1'b0;
    mem_cmd_write = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (state_q == StIssue) begin
      mem_cmd_valid = 1'b1;
      mem_cmd_write = op_write_q;
      mem_addr      = addr_q + beat_offset;
      mem_wdata     = beat_wdata;
    end
  end

  assign physical_resp  = (state_q == StResp);
  assign physical_rdata = rdata_q;
  assign busy           = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    rdata_d    = rdata_q;

    if (cmd_fire) begin
      cmd_cnt_d = cmd_cnt_q + CntW'(1);
    end

    if (beat_capture) begin
      data_cnt_d = data_cnt_q + CntW'(1);
      for (int unsigned b = 0; b < Beats; b++) begin
        if (data_cnt_q == CntW'(b)) begin
          rdata_d[b*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (physical_write) begin
          addr_d     = physical_address & LineMask;
          wdata_d    = physical_wdata;
          op_write_d = 1'b1;
          state_d    = StIssue;
        end else if (physical_read) begin
          addr_d     = physical_address & LineMask;
          op_write_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (cmd_fire && (cmd_cnt_q == LastCnt)) begin
          // A read whose data already arrived alongside its commands skips StDrain.
          if (op_write_q || (data_cnt_d == FullCnt)) begin
            state_d = StResp;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (data_cnt_d == FullCnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        cmd_cnt_d  = '0;
        data_cnt_d = '0;
        state_d    = StHold;
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      cmd_cnt_q  <= cmd_cnt_d;
      data_cnt_q <= data_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: scoreboard queues hold expected beat commands
// and line responses, popped and compared as the DUT issues them.
module tb_line_burst_adapter;

  localparam int unsigned LW    = 128;
  localparam int unsigned BW    = 64;
  localparam int unsigned BEATS = LW / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          physical_read;
  logic          physical_write;
  logic [15:0]   physical_address;
  logic [LW-1:0] physical_wdata;
  logic          physical_resp;
  logic [LW-1:0] physical_rdata;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_write;
  logic [15:0]   mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [BW-1:0] mem_rdata;
  logic          busy;

  line_burst_adapter #(
    .LINE_WIDTH(LW),
    .BEAT_WIDTH(BW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .physical_read    (physical_read),
    .physical_write   (physical_write),
    .physical_address (physical_address),
    .physical_wdata   (physical_wdata),
    .physical_resp    (physical_resp),
    .physical_rdata   (physical_rdata),
    .mem_cmd_valid    (mem_cmd_valid),
    .mem_cmd_ready    (mem_cmd_ready),
    .mem_cmd_write    (mem_cmd_write),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          write;
    logic [15:0]   addr;
    logic [BW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          write;
    logic [LW-1:0] rdata;
  } resp_t;

  cmd_t  exp_cmd_q[$];
  resp_t exp_resp_q[$];
  int    errors = 0;
  int    checks = 0;
  // Line the bench expects physical_rdata to hold between reads.
  logic [LW-1:0] cur_rdata = '0;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({physical_resp, physical_rdata, mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata} !== '0)
    begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b rdata=%h valid=%b write=%b addr=%h wdata=%h want 0",
               physical_resp, physical_rdata, mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n     = 1'b1;
    cur_rdata = '0;
  endtask

  // Zero-wait read: ready immediately and each beat's data returned alongside its command.
  task automatic test_read_zero_wait(input logic [15:0] addr, input logic [BW-1:0] b0,
                                     input logic [BW-1:0] b1, input string tag);
    logic [BW-1:0] beats [BEATS];
    cmd_t  c;
    resp_t r;
    int    lat = 1;
    int    k = 0;
    bit    done = 0;
    beats[0] = b0;
    beats[1] = b1;
    exp_cmd_q.push_back(cmd_t'{1'b0, addr & 16'hFFF0, '0});
    exp_cmd_q.push_back(cmd_t'{1'b0, (addr & 16'hFFF0) + 16'h8, '0});
    exp_resp_q.push_back(resp_t'{1'b0, {b1, b0}});
    physical_address = addr;
    physical_read    = 1'b1;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      lat++;
      mem_rvalid = 1'b0;
      if (physical_resp) begin
        r = exp_resp_q.pop_front();
        checks++;
        if (lat != BEATS + 2) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles want %0d", tag, lat, BEATS + 2);
        end
        checks++;
        if (physical_rdata !== r.rdata) begin
          errors++;
          $display("FAIL %s_rdata: got %h want %h", tag, physical_rdata, r.rdata);
        end
        physical_read = 1'b0;
        mem_cmd_ready = 1'b0;
        cur_rdata     = r.rdata;
        done          = 1;
      end else if (mem_cmd_valid) begin
        if (exp_cmd_q.size() == 0 || k >= BEATS) begin
          errors++;
          $display("FAIL %s_extra_cmd: got addr=%h want no command", tag, mem_addr);
        end else begin
          c = exp_cmd_q.pop_front();
          checks++;
          if ({mem_cmd_write, mem_addr} !== {c.write, c.addr}) begin
            errors++;
            $display("FAIL %s_cmd: got write=%b addr=%h want write=%b addr=%h", tag,
                     mem_cmd_write, mem_addr, c.write, c.addr);
          end
          mem_cmd_ready = 1'b1;
          mem_rvalid    = 1'b1;
          mem_rdata     = beats[k];
          k++;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no physical_resp want one", tag);
    end
    // Late rvalid during RESP/HOLD lies beyond the line and must be dropped.
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    checks++;
    if (physical_resp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_hold: got resp=%b busy=%b want resp=0 busy=1", tag, physical_resp, busy);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (busy !== 1'b0 || physical_rdata !== cur_rdata) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b rdata=%h want busy=0 rdata=%h", tag, busy,
               physical_rdata, cur_rdata);
    end
  endtask

  task automatic test_write_backpressure();
    logic [LW-1:0] wd = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    cmd_t  c;
    resp_t r;
    int    lat = 1;
    int    stall = 0;
    int    accepted = 0;
    bit    done = 0;
    exp_cmd_q.push_back(cmd_t'{1'b1, 16'h0040, wd[63:0]});
    exp_cmd_q.push_back(cmd_t'{1'b1, 16'h0048, wd[127:64]});
    exp_resp_q.push_back(resp_t'{1'b1, cur_rdata});
    physical_address = 16'h0040;
    physical_wdata   = wd;
    physical_write   = 1'b1;
    mem_cmd_ready    = 1'b0;
    mem_rvalid       = 1'b1;
    mem_rdata        = 64'hDEAD_BEEF_0000_0000;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      lat++;
      // Requester inputs wander after the latch; the transfer must not follow them.
      physical_address = 16'hFFF0;
      physical_wdata   = '1;
      if (physical_resp) begin
        r = exp_resp_q.pop_front();
        checks++;
        if (accepted != BEATS || lat != BEATS + 2 + 3) begin
          errors++;
          $display("FAIL wr_resp_timing: got accepted=%0d lat=%0d want accepted=%0d lat=%0d",
                   accepted, lat, BEATS, BEATS + 5);
        end
        checks++;
        if (physical_rdata !== r.rdata) begin
          errors++;
          $display("FAIL wr_rdata_kept: got %h want %h", physical_rdata, r.rdata);
        end
        physical_write = 1'b0;
        mem_cmd_ready  = 1'b0;
        done           = 1;
      end else if (mem_cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL wr_extra_cmd: got addr=%h want no command", mem_addr);
        end else begin
          c = exp_cmd_q[0];
          checks++;
          if ({mem_cmd_write, mem_addr, mem_wdata} !== {c.write, c.addr, c.wdata}) begin
            errors++;
            $display("FAIL wr_beat: got write=%b addr=%h wdata=%h want write=%b addr=%h wdata=%h",
                     mem_cmd_write, mem_addr, mem_wdata, c.write, c.addr, c.wdata);
          end
          if (stall < 3) begin
            mem_cmd_ready = 1'b0;
            stall++;
          end else begin
            mem_cmd_ready = 1'b1;
            c = exp_cmd_q.pop_front();
            accepted++;
          end
        end
      end else begin
        mem_cmd_ready = 1'b0;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL wr_timeout: got no physical_resp want one");
    end
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [LW-1:0] wd = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [BW-1:0] beats [BEATS];
    cmd_t  c;
    resp_t r;
    int    k = 0;
    int    since_wr = 0;
    bit    done = 0;
    beats[0] = 64'h5555_0000_0000_0001;
    beats[1] = 64'h6666_0000_0000_0002;
    exp_cmd_q.push_back(cmd_t'{1'b1, 16'h0100, wd[63:0]});
    exp_cmd_q.push_back(cmd_t'{1'b1, 16'h0108, wd[127:64]});
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0100, '0});
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0108, '0});
    exp_resp_q.push_back(resp_t'{1'b1, cur_rdata});
    exp_resp_q.push_back(resp_t'{1'b0, {beats[1], beats[0]}});
    physical_address = 16'h0100;
    physical_wdata   = wd;
    physical_write   = 1'b1;
    physical_read    = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (since_wr > 0) since_wr++;
      if (since_wr == 2) begin
        checks++;
        if (mem_cmd_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL sim_hold: got valid=%b busy=%b want valid=0 busy=1", mem_cmd_valid, busy);
        end
      end
      if (since_wr == 3) begin
        checks++;
        if (mem_cmd_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL sim_idle: got valid=%b busy=%b want valid=0 busy=0", mem_cmd_valid, busy);
        end
      end
      if (physical_resp) begin
        if (exp_resp_q.size() == 0) begin
          errors++;
          $display("FAIL sim_extra_resp: got resp=1 want 0");
          done = 1;
        end else begin
          r = exp_resp_q.pop_front();
          checks++;
          if (physical_rdata !== r.rdata) begin
            errors++;
            $display("FAIL sim_rdata: got %h want %h (write=%b)", physical_rdata, r.rdata, r.write);
          end
          mem_cmd_ready = 1'b0;
          if (r.write) begin
            physical_write = 1'b0;
            since_wr       = 1;
          end else begin
            physical_read = 1'b0;
            cur_rdata     = r.rdata;
            done          = 1;
          end
        end
      end else if (mem_cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL sim_extra_cmd: got addr=%h want no command", mem_addr);
        end else begin
          c = exp_cmd_q.pop_front();
          checks++;
          if ({mem_cmd_write, mem_addr, (c.write ? mem_wdata : 64'h0)} !==
              {c.write, c.addr, c.wdata}) begin
            errors++;
            $display("FAIL sim_cmd: got write=%b addr=%h wdata=%h want write=%b addr=%h wdata=%h",
                     mem_cmd_write, mem_addr, mem_wdata, c.write, c.addr, c.wdata);
          end
          mem_cmd_ready = 1'b1;
          if (!c.write && k < BEATS) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beats[k];
            k++;
          end
        end
      end else begin
        mem_cmd_ready = 1'b0;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL sim_timeout: got incomplete sequence want write then read");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_delayed_read();
    logic [BW-1:0] beats [BEATS];
    cmd_t  c;
    resp_t r;
    int    a0 = -1;
    int    last_rv = -100;
    int    k = 0;
    bit    done = 0;
    beats[0] = 64'h0123_4567_89AB_CDEF;
    beats[1] = 64'hFEDC_BA98_7654_3210;
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0300, '0});
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0308, '0});
    exp_resp_q.push_back(resp_t'{1'b0, {beats[1], beats[0]}});
    physical_address = 16'h030C;
    physical_read    = 1'b1;
    for (int cyc = 1; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (physical_resp) begin
        r = exp_resp_q.pop_front();
        checks++;
        if (cyc != last_rv + 1) begin
          errors++;
          $display("FAIL dly_resp_cycle: got %0d want %0d", cyc, last_rv + 1);
        end
        checks++;
        if (physical_rdata !== r.rdata) begin
          errors++;
          $display("FAIL dly_rdata: got %h want %h", physical_rdata, r.rdata);
        end
        physical_read = 1'b0;
        cur_rdata     = r.rdata;
        done          = 1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL dly_busy: got %b want 1 at cycle %0d", busy, cyc);
        end
        if (mem_cmd_valid) begin
          if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL dly_extra_cmd: got addr=%h want no command", mem_addr);
          end else begin
            c = exp_cmd_q.pop_front();
            checks++;
            if ({mem_cmd_write, mem_addr} !== {c.write, c.addr}) begin
              errors++;
              $display("FAIL dly_cmd: got write=%b addr=%h want write=%b addr=%h",
                       mem_cmd_write, mem_addr, c.write, c.addr);
            end
          end
          mem_cmd_ready = 1'b1;
          if (a0 < 0) a0 = cyc;
        end else begin
          mem_cmd_ready = 1'b0;
        end
        if (a0 >= 0 && (cyc == a0 + 5 || cyc == a0 + 9) && k < BEATS) begin
          checks++;
          if (mem_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL dly_drain: got valid=%b want 0 while waiting for data", mem_cmd_valid);
          end
          mem_rvalid = 1'b1;
          mem_rdata  = beats[k];
          k++;
          last_rv    = cyc;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL dly_timeout: got no physical_resp want one");
    end
    mem_cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bit accepted = 0;
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0500, '0});
    exp_cmd_q.push_back(cmd_t'{1'b0, 16'h0508, '0});
    exp_resp_q.push_back(resp_t'{1'b0, '0});
    physical_address = 16'h0500;
    physical_read    = 1'b1;
    for (int cyc = 0; cyc < 10 && !accepted; cyc++) begin
      @(negedge clk);
      if (mem_cmd_valid) begin
        mem_cmd_ready = 1'b1;
        accepted      = 1;
      end
    end
    @(negedge clk);
    rst_n         = 1'b0;
    mem_cmd_ready = 1'b0;
    physical_read = 1'b0;
    #1;
    checks++;
    if ({physical_resp, physical_rdata, mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata, busy}
        !== '0 || !accepted) begin
      errors++;
      $display("FAIL rst_mid_outputs: got resp=%b rdata=%h valid=%b addr=%h busy=%b want all 0",
               physical_resp, physical_rdata, mem_cmd_valid, mem_addr, busy);
    end
    // The interrupted line is abandoned: no beats or response will follow.
    exp_cmd_q.delete();
    exp_resp_q.delete();
    cur_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (physical_resp !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_resp: got resp=%b busy=%b want 0 0", physical_resp, busy);
    end
    test_read_zero_wait(16'h2000, 64'h2000_0000_0000_00A0, 64'h2000_0000_0000_00B0,
                        "rd_after_reset");
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_0000_DEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (physical_rdata !== cur_rdata || busy !== 1'b0 || mem_cmd_valid !== 1'b0 ||
          physical_resp !== 1'b0) begin
        errors++;
        $display("FAIL stray_rvalid: got rdata=%h busy=%b valid=%b resp=%b want rdata=%h idle",
                 physical_rdata, busy, mem_cmd_valid, physical_resp, cur_rdata);
      end
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    physical_read    = 1'b0;
    physical_write   = 1'b0;
    physical_address = '0;
    physical_wdata   = '0;
    mem_cmd_ready    = 1'b0;
    mem_rvalid       = 1'b0;
    mem_rdata        = '0;
    test_reset();
    test_read_zero_wait(16'h1234, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                        "rd_zero_wait");
    test_write_backpressure();
    test_simultaneous();
    test_delayed_read();
    test_reset_mid_read();
    test_stray_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
